// File: rtl/fetch_controller_pkg.sv
// rtl/fetch_controller_pkg.sv - shared constants and state type for the fetch path
package fetch_controller_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          WORD_BYTES       = 4;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        DRAIN = ST_DRAIN,
        HOLD  = ST_HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - IF/ID output bundle and freeze-time instruction buffer
module fetch_buffer #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_sel_hold,
    input  logic               i_hold_load,
    input  logic               i_flush,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [INSTR_W-1:0] i_rdata,
    output logic               o_valid,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instruction
);

    logic               r_valid;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instruction;
    logic [INSTR_W-1:0] r_hold_buf;
    logic [INSTR_W-1:0] w_src;

    assign w_src = i_sel_hold ? r_hold_buf : i_rdata;

    // A flush only invalidates; pc/instruction keep their last values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_instruction <= '0;
            r_hold_buf    <= '0;
        end else begin
            if (i_hold_load) begin
                r_hold_buf <= i_rdata;
            end
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid       <= 1'b1;
                r_pc          <= i_pc;
                r_instruction <= w_src;
            end
        end
    end

    assign o_valid       = r_valid;
    assign o_pc          = r_pc;
    assign o_instruction = r_instruction;

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC owner and request/ready instruction fetch sequencer
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_freeze,
    input  logic               i_branch_taken,
    input  logic [PC_W-1:0]    i_branch_addr,
    output logic               o_mem_req,
    output logic [PC_W-1:0]    o_mem_addr,
    input  logic               i_mem_ready,
    input  logic [INSTR_W-1:0] i_mem_rdata,
    output logic               o_if_valid,
    output logic [PC_W-1:0]    o_if_pc,
    output logic [INSTR_W-1:0] o_if_instruction
);

    fetch_state_t    r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [PC_W-1:0] r_req_addr, w_req_addr_nxt;
    logic [PC_W-1:0] w_addr_inc;
    logic            w_load, w_sel_hold, w_hold_load, w_flush;

    assign w_addr_inc = r_req_addr + PC_W'(WORD_BYTES);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_load         = 1'b0;
        w_sel_hold     = 1'b0;
        w_hold_load    = 1'b0;
        w_flush        = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt    = REQ;
                w_req_addr_nxt = r_pc;
            end
            REQ: begin
                if (i_mem_ready) begin
                    if (i_branch_taken) begin
                        w_flush        = 1'b1;
                        w_pc_nxt       = i_branch_addr;
                        w_req_addr_nxt = i_branch_addr;
                    end else if (i_freeze) begin
                        w_hold_load = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_load         = 1'b1;
                        w_pc_nxt       = w_addr_inc;
                        w_req_addr_nxt = w_addr_inc;
                    end
                end else if (i_branch_taken) begin
                    // The bus address must stay put until the in-flight fetch completes.
                    w_flush     = 1'b1;
                    w_pc_nxt    = i_branch_addr;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (i_branch_taken) begin
                    w_pc_nxt = i_branch_addr;
                end
                if (i_mem_ready) begin
                    w_req_addr_nxt = i_branch_taken ? i_branch_addr : r_pc;
                    w_state_nxt    = REQ;
                end
            end
            HOLD: begin
                if (i_branch_taken) begin
                    w_flush        = 1'b1;
                    w_pc_nxt       = i_branch_addr;
                    w_req_addr_nxt = i_branch_addr;
                    w_state_nxt    = REQ;
                end else if (!i_freeze) begin
                    w_load         = 1'b1;
                    w_sel_hold     = 1'b1;
                    w_pc_nxt       = w_addr_inc;
                    w_req_addr_nxt = w_addr_inc;
                    w_state_nxt    = REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_mem_req  = (r_state == REQ) || (r_state == DRAIN);
    assign o_mem_addr = r_req_addr;

    fetch_buffer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_fetch_buffer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_load        (w_load),
        .i_sel_hold    (w_sel_hold),
        .i_hold_load   (w_hold_load),
        .i_flush       (w_flush),
        .i_pc          (w_addr_inc),
        .i_rdata       (i_mem_rdata),
        .o_valid       (o_if_valid),
        .o_pc          (o_if_pc),
        .o_instruction (o_if_instruction)
    );

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the instruction-fetch path of the ARM pipeline. It owns the program counter and drives a request/ready instruction-memory port, which allows variable memory latency. It applies branch redirects and hazard freezes, and presents a registered {valid, pc, instruction} bundle to the IF/ID pipeline register. It sits between the EX-stage branch logic and hazard unit on one side, and the instruction memory on the other.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `PC_W`, 32, address/PC width.
- `INSTR_W`, 32, instruction width.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `freeze` in 1: hazard-unit stall; hold the output bundle.
- `branch_taken` in 1: redirect request from EX.
- `branch_addr` in PC_W: redirect target.
- `mem_req` out 1: memory request, held until accepted.
- `mem_addr` out PC_W: fetch address, stable while `mem_req` is high.
- `mem_ready` in 1: memory completes the request this cycle with `mem_rdata`.
- `mem_rdata` in INSTR_W: fetched instruction.
- `if_valid` out 1: output bundle holds a real instruction.
- `if_pc` out PC_W: fetch address + 4.
- `if_instruction` out INSTR_W: fetched instruction.

## Operation
- States:
  - IDLE: post-reset, one cycle.
  - REQ: request outstanding.
  - DRAIN: request outstanding, result to be discarded.
  - HOLD: result buffered during freeze.
- Registers:
  - `pc`: next fetch address.
  - `req_addr`: drives `mem_addr`.
  - `hold_buf`: instruction buffered while frozen.
  - Output bundle.
- `mem_req` = (state == REQ || state == DRAIN). `mem_addr` = `req_addr`. `mem_ready` is ignored when `mem_req` is low.
- IDLE → REQ unconditionally, with `req_addr` <= `pc`.
- REQ, when `mem_ready` is high:
  - `branch_taken`: discard data; `if_valid` <= 0; `pc`, `req_addr` <= `branch_addr`; stay in REQ.
  - else `freeze`: `hold_buf` <= `mem_rdata`; go to HOLD; output bundle unchanged.
  - else: bundle <= {1, `req_addr`+4, `mem_rdata`}; `pc`, `req_addr` <= `req_addr`+4; stay in REQ.
- REQ, when `mem_ready` is low:
  - `branch_taken`: `pc` <= `branch_addr`; `if_valid` <= 0; go to DRAIN. `req_addr` is unchanged, because an address must not change mid-request.
  - `freeze` alone: no effect.
- DRAIN: on `mem_ready`, discard data, set `req_addr` <= `pc`, go to REQ.
  - A further `branch_taken` while in DRAIN overwrites `pc`; the last redirect wins.
- HOLD: `mem_req` = 0.
  - `branch_taken`: drop buffer; `if_valid` <= 0; `pc`, `req_addr` <= `branch_addr`; go to REQ.
  - else `!freeze`: bundle <= {1, `req_addr`+4, `hold_buf`}; `pc`, `req_addr` <= `req_addr`+4; go to REQ.
- Priority, all states: `rst` > `branch_taken` > `freeze`.
- `branch_taken` with `freeze` in REQ/HOLD: the flush is applied and `if_valid` <= 0 even though the bundle is frozen.
- Arithmetic: PC+4 is modulo 2^PC_W. 32'hFFFF_FFFC wraps to 0 with no flag.
- Reset, including mid-request: state IDLE, `pc` = `req_addr` = `RESET_PC`, `mem_req` = 0, `if_valid` = 0, `if_pc` = 0, `if_instruction` = 0, `hold_buf` = 0. An abandoned memory request is dropped; the memory must tolerate `mem_req` falling.

## Timing
- The first request is visible in the cycle after `rst` deasserts, plus one cycle for IDLE.
- Zero-wait memory (`mem_ready` high in the cycle `mem_req` rises): one instruction per cycle, with the bundle valid on the following edge.
- N wait cycles: the bundle updates N+1 cycles after the request starts.
- A redirect in REQ with ready high: the new address is requested on the next cycle (1-cycle bubble).
- A redirect in REQ with ready low: the target is requested on the cycle after the discarded completion.
- HOLD → REQ on freeze release: the buffered instruction appears on that edge, and the next request issues in the same cycle the new state is entered.
- All outputs are registered except `mem_req`/`mem_addr`, which decode from state/`req_addr` and are glitch-free.

## Structure
- The shared package holds:
  - State encoding localparams (IDLE/REQ/DRAIN/HOLD).
  - `RESET_PC` default.
  - `WORD_BYTES` = 4.
- One sub-module, `fetch_buffer`: the output bundle plus `hold_buf`, with load/flush/select controls. The FSM stays in `fetch_controller`.

## Test plan
- Zero-wait memory, `mem_rdata` = address ^ 32'hA5A5_0000, no freeze: after reset, `mem_addr` = 0, 4, 8, 12 on consecutive cycles; `if_pc` = 4, 8, 12, 16 with `if_valid` = 1 from the cycle following the first request.
- Memory with 2 wait states: `mem_addr` = 0 held for 3 cycles; bundle {1, 4, data0} appears once; `mem_addr` moves to 4 only after ready.
- `branch_taken`, `branch_addr` = 32'h100, raised in the first wait cycle of fetch 8: `mem_addr` stays 8 until ready; data is discarded and `if_valid` = 0; the next request is 32'h100 and the next bundle is `if_pc` = 32'h104.
- `freeze` high for 3 cycles coinciding with ready on fetch 4: bundle holds {1, 4, data0}; `mem_req` = 0 in HOLD; on release the bundle = {1, 8, data4} and the next request is 8.
- `freeze` and `branch_taken` (target 32'h40) together in HOLD: `if_valid` = 0, buffer dropped, next request 32'h40.
- `rst` asserted during a wait state at address 32'hC, and `pc` = 32'hFFFF_FFFC wrap: `mem_req` = 0 and outputs zero the next cycle, then the fetch restarts at 0; the separately-started wrap case fetches 32'hFFFF_FFFC then 0.
